axis_skid_reg: RTL

Two-entry AXI4-Stream register slice (skid buffer) placed directly downstream of a stream master's TVALID/TDATA output. It fully registers both the forward path (M_TVALID, M_TDATA) and the backward path (S_TREADY), sustaining one beat per cycle with one cycle of latency. It enforces reset-compliant output timing: M_TVALID is never driven high before the edge that follows the first edge sampling ARESETn high. It also flags upstream handshake violations with a sticky error bit.

---
 rtl/axis_skid_reg.sv | 114 +++++++++++
 1 files changed

// File: rtl/axis_skid_reg.sv
// Two-entry AXI4-Stream register slice with registered TVALID/TDATA/TREADY and a sticky upstream protocol checker.
// Optional feature macro: AXIS_TLAST_EN (adds S_TLAST, M_TLAST and PKT_CNT).
module axis_skid_reg #(
   parameter int DATA_W = 32
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              S_TVALID,
   output logic              S_TREADY,
   input  logic [DATA_W-1:0] S_TDATA,
`ifdef AXIS_TLAST_EN
   input  logic              S_TLAST,
`endif
   output logic              M_TVALID,
   input  logic              M_TREADY,
   output logic [DATA_W-1:0] M_TDATA,
`ifdef AXIS_TLAST_EN
   output logic              M_TLAST,
   output logic [15:0]       PKT_CNT,
`endif
   output logic              PROTO_ERR
);

`ifdef AXIS_TLAST_EN
   localparam int BW = DATA_W + 1;
`else
   localparam int BW = DATA_W;
`endif

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t          state_q, state_nxt;
   logic [BW-1:0]   out_q, skid_q, s_beat, stall_q;
   logic            load_out, out_from_skid, load_skid;
   logic            s_hs, m_hs, stalled_q;

`ifdef AXIS_TLAST_EN
   assign s_beat             = {S_TLAST, S_TDATA};
   assign {M_TLAST, M_TDATA} = out_q;
`else
   assign s_beat  = S_TDATA;
   assign M_TDATA = out_q;
`endif

   assign s_hs = S_TVALID & S_TREADY;
   assign m_hs = M_TVALID & M_TREADY;

   always_comb begin
      state_nxt     = state_q;
      load_out      = 1'b0;
      out_from_skid = 1'b0;
      load_skid     = 1'b0;
      case (state_q)
         EMPTY: if (s_hs) begin
            load_out  = 1'b1;
            state_nxt = ONE;
         end
         ONE: begin
            if (s_hs && m_hs) begin
               load_out = 1'b1;
            end else if (s_hs) begin
               load_skid = 1'b1;
               state_nxt = FULL;
            end else if (m_hs) begin
               state_nxt = EMPTY;
            end
         end
         FULL: if (m_hs) begin
            load_out      = 1'b1;
            out_from_skid = 1'b1;
            state_nxt     = ONE;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Ready and valid come straight from flops, decoded from the next state.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q  <= EMPTY;
         S_TREADY <= 1'b0;
         M_TVALID <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         S_TREADY <= (state_nxt != FULL);
         M_TVALID <= (state_nxt != EMPTY);
      end
   end

   // Payload registers carry no reset; state alone decides whether they hold a beat.
   always_ff @(posedge ACLK) begin
      if (load_out)  out_q  <= out_from_skid ? skid_q : s_beat;
      if (load_skid) skid_q <= s_beat;
      stall_q <= s_beat;
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         stalled_q <= 1'b0;
         PROTO_ERR <= 1'b0;
      end else begin
         stalled_q <= S_TVALID & ~S_TREADY;
         if (stalled_q && (!S_TVALID || s_beat != stall_q)) PROTO_ERR <= 1'b1;
      end
   end

`ifdef AXIS_TLAST_EN
   always_ff @(posedge ACLK) begin
      if (!ARESETn)              PKT_CNT <= '0;
      else if (m_hs && M_TLAST)  PKT_CNT <= PKT_CNT + 16'd1;
   end
`endif

endmodule
